// File: rtl/logic_gate_pipe.sv
// Two-stage registered bitwise reduction of NUM_IN operands with valid/ready
// handshakes on both sides; S1 captures operands, S2 holds the computed result.
module logic_gate_pipe #(
    parameter int WIDTH  = 8,
    parameter int NUM_IN = 2
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [NUM_IN*WIDTH-1:0] in_data,
    input  logic [2:0]              op,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [WIDTH-1:0]        out,
    output logic                    out_any,
    output logic                    op_err
);

    localparam logic [2:0] OP_OR   = 3'd0;
    localparam logic [2:0] OP_AND  = 3'd1;
    localparam logic [2:0] OP_XOR  = 3'd2;
    localparam logic [2:0] OP_NOR  = 3'd3;
    localparam logic [2:0] OP_NAND = 3'd4;
    localparam logic [2:0] OP_XNOR = 3'd5;

    logic                    s1_valid_reg;
    logic [NUM_IN*WIDTH-1:0] s1_data_reg;
    logic [2:0]              s1_op_reg;
    logic                    s2_valid_reg;
    logic [WIDTH-1:0]        out_reg;
    logic                    out_any_reg;
    logic                    op_err_reg;

    logic                    adv1;
    logic                    adv2;
    logic [WIDTH-1:0]        operand [NUM_IN];
    logic [WIDTH-1:0]        or_all;
    logic [WIDTH-1:0]        and_all;
    logic [WIDTH-1:0]        xor_all;
    logic [WIDTH-1:0]        result_next;
    logic                    err_next;

    // S2 may take S1 when it is empty or being drained this same edge.
    assign adv2      = s1_valid_reg & (~s2_valid_reg | out_ready);
    assign in_ready  = ~s1_valid_reg | adv2;
    assign adv1      = in_valid & in_ready;
    assign out_valid = s2_valid_reg;
    assign out       = out_reg;
    assign out_any   = out_any_reg;
    assign op_err    = op_err_reg;

    generate
        for (genvar gi = 0; gi < NUM_IN; gi++) begin : g_operand
            assign operand[gi] = s1_data_reg[gi*WIDTH +: WIDTH];
        end
    endgenerate

    always_comb begin
        or_all  = operand[0];
        and_all = operand[0];
        xor_all = operand[0];
        for (int k = 1; k < NUM_IN; k++) begin
            or_all  = or_all  | operand[k];
            and_all = and_all & operand[k];
            xor_all = xor_all ^ operand[k];
        end
    end

    always_comb begin
        result_next = '0;
        err_next    = 1'b0;
        case (s1_op_reg)
            OP_OR:   result_next = or_all;
            OP_AND:  result_next = and_all;
            OP_XOR:  result_next = xor_all;
            OP_NOR:  result_next = ~or_all;
            OP_NAND: result_next = ~and_all;
            OP_XNOR: result_next = ~xor_all;
            default: err_next    = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_reg <= 1'b0;
            s1_data_reg  <= '0;
            s1_op_reg    <= '0;
        end else if (adv1) begin
            s1_valid_reg <= 1'b1;
            s1_data_reg  <= in_data;
            s1_op_reg    <= op;
        end else if (adv2) begin
            s1_valid_reg <= 1'b0;
        end
    end

    // Result registers only move on adv2, so they hold while stalled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_valid_reg <= 1'b0;
            out_reg      <= '0;
            out_any_reg  <= 1'b0;
            op_err_reg   <= 1'b0;
        end else if (adv2) begin
            s2_valid_reg <= 1'b1;
            out_reg      <= result_next;
            out_any_reg  <= |result_next;
            op_err_reg   <= err_next;
        end else if (out_ready) begin
            s2_valid_reg <= 1'b0;
        end
    end

endmodule

// File: tb/tb_logic_gate_pipe.sv
// Bench for logic_gate_pipe: truth tables on 1-bit and 3-operand instances,
// plus a randomized scoreboarded stream and stall/reset sequences on the 8x2 instance.
module tb_logic_gate_pipe;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    // main instance: WIDTH=8, NUM_IN=2
    logic        a_in_valid = 0, a_in_ready, a_out_valid, a_out_ready = 0, a_out_any, a_op_err;
    logic [15:0] a_in_data = 0;
    logic [2:0]  a_op = 0;
    logic [7:0]  a_out;
    // truth-sweep instance: WIDTH=1, NUM_IN=2
    logic        b_in_valid = 0, b_in_ready, b_out_valid, b_out_ready = 0, b_out_any, b_op_err;
    logic [1:0]  b_in_data = 0;
    logic [2:0]  b_op = 0;
    logic [0:0]  b_out;
    // multi-operand instance: WIDTH=8, NUM_IN=3
    logic        c_in_valid = 0, c_in_ready, c_out_valid, c_out_ready = 0, c_out_any, c_op_err;
    logic [23:0] c_in_data = 0;
    logic [2:0]  c_op = 0;
    logic [7:0]  c_out;

    logic_gate_pipe #(.WIDTH(8), .NUM_IN(2)) dut_a (
        .clk(clk), .rst_n(rst_n), .in_valid(a_in_valid), .in_ready(a_in_ready),
        .in_data(a_in_data), .op(a_op), .out_valid(a_out_valid), .out_ready(a_out_ready),
        .out(a_out), .out_any(a_out_any), .op_err(a_op_err));
    logic_gate_pipe #(.WIDTH(1), .NUM_IN(2)) dut_b (
        .clk(clk), .rst_n(rst_n), .in_valid(b_in_valid), .in_ready(b_in_ready),
        .in_data(b_in_data), .op(b_op), .out_valid(b_out_valid), .out_ready(b_out_ready),
        .out(b_out), .out_any(b_out_any), .op_err(b_op_err));
    logic_gate_pipe #(.WIDTH(8), .NUM_IN(3)) dut_c (
        .clk(clk), .rst_n(rst_n), .in_valid(c_in_valid), .in_ready(c_in_ready),
        .in_data(c_in_data), .op(c_op), .out_valid(c_out_valid), .out_ready(c_out_ready),
        .out(c_out), .out_any(c_out_any), .op_err(c_op_err));

    typedef struct {
        logic [23:0] data;
        logic [2:0]  op;
        logic [7:0]  exp_out;
        logic        exp_any;
        logic        exp_err;
    } vec_t;

    int          total = 0;
    int          bad = 0;
    int          delivered = 0;
    logic [31:0] exp_q [$];
    logic        hold_pending = 0;
    logic [31:0] hold_val = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end else begin
            $display("ok   %s value=%0h", name, act);
        end
    endtask

    // Per-bit ones count across operands decides every op.
    function automatic logic [31:0] ref_model(input logic [15:0] d, input logic [2:0] o);
        logic [7:0] r;
        int cnt;
        r = '0;
        for (int b = 0; b < 8; b++) begin
            cnt = int'(d[b]) + int'(d[8+b]);
            case (o)
                3'd0: r[b] = (cnt > 0);
                3'd1: r[b] = (cnt == 2);
                3'd2: r[b] = (cnt % 2 == 1);
                3'd3: r[b] = (cnt == 0);
                3'd4: r[b] = (cnt != 2);
                3'd5: r[b] = (cnt % 2 == 0);
                default: r[b] = 1'b0;
            endcase
        end
        return {22'd0, (o > 3'd5), (r != 8'd0), r};
    endfunction

    // One cycle on dut_a: drive at negedge, sample 1ns later, score handshakes of the coming edge.
    task automatic step_a(input logic v, input logic [15:0] d, input logic [2:0] o,
                          input logic r, output logic took);
        logic [31:0] act;
        @(negedge clk);
        a_in_valid = v; a_in_data = d; a_op = o; a_out_ready = r;
        #1;
        act = {22'd0, a_op_err, a_out_any, a_out};
        if (hold_pending) begin
            check("hold_valid", {31'd0, a_out_valid}, 32'd1);
            check("hold_data", act, hold_val);
        end
        if (a_out_valid && a_out_ready) begin
            if (exp_q.size() == 0) check("spurious_out", act, 32'hFFFF_FFFF);
            else check("result", act, exp_q.pop_front());
            delivered++;
        end
        hold_pending = a_out_valid && !a_out_ready;
        hold_val = act;
        took = v && a_in_ready;
        if (took) exp_q.push_back(ref_model(d, o));
    endtask

    task automatic drain_a();
        int n;
        logic t;
        n = 0;
        while ((exp_q.size() != 0 || a_out_valid) && n < 50) begin
            step_a(1'b0, 16'd0, 3'd0, 1'b1, t);
            n++;
        end
        if (n >= 50) check("drain_timeout", 32'd1, 32'd0);
    endtask

    task automatic reset_mid(input string tag);
        @(negedge clk);
        #2;
        a_in_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        check({tag, "_out_valid"}, {31'd0, a_out_valid}, 32'd0);
        check({tag, "_out"}, {24'd0, a_out}, 32'd0);
        check({tag, "_out_any"}, {31'd0, a_out_any}, 32'd0);
        check({tag, "_op_err"}, {31'd0, a_op_err}, 32'd0);
        exp_q.delete();
        hold_pending = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check({tag, "_in_ready"}, {31'd0, a_in_ready}, 32'd1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

    initial begin
        vec_t        tv_b [24];
        vec_t        tv_c [8];
        logic [3:0]  tt [6];
        logic [7:0]  c_out_tab [8];
        logic [7:0]  c_any_tab;
        logic        took;
        logic        cur_v;
        logic [15:0] cur_d;
        logic [2:0]  cur_o;
        logic [15:0] pb_d [5];
        logic [2:0]  pb_o [5];
        int          idx, base, first_c, last_c, n;

        // truth patterns indexed by input pair i = {operand1, operand0}
        tt[0] = 4'b1110; tt[1] = 4'b1000; tt[2] = 4'b0110;
        tt[3] = 4'b0001; tt[4] = 4'b0111; tt[5] = 4'b1001;
        for (int o = 0; o < 6; o++)
            for (int i = 0; i < 4; i++) begin
                tv_b[o*4+i].data    = 24'(i);
                tv_b[o*4+i].op      = 3'(o);
                tv_b[o*4+i].exp_out = {7'd0, tt[o][i]};
                tv_b[o*4+i].exp_any = tt[o][i];
                tv_b[o*4+i].exp_err = 1'b0;
            end
        c_out_tab[0] = 8'hFF; c_out_tab[1] = 8'h00; c_out_tab[2] = 8'hC3; c_out_tab[3] = 8'h00;
        c_out_tab[4] = 8'hFF; c_out_tab[5] = 8'h3C; c_out_tab[6] = 8'h00; c_out_tab[7] = 8'h00;
        c_any_tab = 8'b0011_0101;
        for (int o = 0; o < 8; o++) begin
            tv_c[o].data    = {8'h0F, 8'h3C, 8'hF0};
            tv_c[o].op      = 3'(o);
            tv_c[o].exp_out = c_out_tab[o];
            tv_c[o].exp_any = c_any_tab[o];
            tv_c[o].exp_err = (o >= 6);
        end

        // power-on reset: outputs cleared without any clock edge
        #1 rst_n = 1'b0;
        #2;
        check("por_out_valid", {31'd0, a_out_valid}, 32'd0);
        check("por_out", {24'd0, a_out}, 32'd0);
        check("por_op_err", {31'd0, a_op_err}, 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("por_in_ready", {31'd0, a_in_ready}, 32'd1);

        // WIDTH=1 truth sweep, result visible two edges after acceptance
        for (int i = 0; i < 24; i++) begin
            @(negedge clk);
            b_in_valid = 1'b1; b_in_data = tv_b[i].data[1:0]; b_op = tv_b[i].op; b_out_ready = 1'b1;
            #1 check("b_in_ready", {31'd0, b_in_ready}, 32'd1);
            @(negedge clk);
            b_in_valid = 1'b0;
            #1 check("b_lat_early", {31'd0, b_out_valid}, 32'd0);
            @(negedge clk);
            #1 check("b_lat_valid", {31'd0, b_out_valid}, 32'd1);
            check($sformatf("b_op%0d_in%0d", tv_b[i].op, i % 4),
                  {29'd0, b_op_err, b_out_any, b_out},
                  {29'd0, tv_b[i].exp_err, tv_b[i].exp_any, tv_b[i].exp_out[0]});
        end

        // three operands 0xF0, 0x3C, 0x0F
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            c_in_valid = 1'b1; c_in_data = tv_c[i].data; c_op = tv_c[i].op; c_out_ready = 1'b1;
            @(negedge clk);
            c_in_valid = 1'b0;
            @(negedge clk);
            #1 check("c_valid", {31'd0, c_out_valid}, 32'd1);
            check($sformatf("c_op%0d", tv_c[i].op), {22'd0, c_op_err, c_out_any, c_out},
                  {22'd0, tv_c[i].exp_err, tv_c[i].exp_any, tv_c[i].exp_out});
        end

        // randomized stream; upstream holds an unaccepted bundle
        cur_v = 1'b0; cur_d = 16'd0; cur_o = 3'd0;
        for (int cyc = 0; cyc < 400; cyc++) begin
            if (!cur_v) begin
                cur_v = ($urandom_range(0, 9) < 7);
                cur_d = 16'($urandom);
                cur_o = 3'($urandom_range(0, 7));
            end
            step_a(cur_v, cur_d, cur_o, ($urandom_range(0, 9) < 6), took);
            if (took) cur_v = 1'b0;
        end
        drain_a();

        // back-pressure: 5 bundles, out_ready low for 4 cycles
        for (int i = 0; i < 5; i++) begin
            pb_d[i] = 16'($urandom);
            pb_o[i] = 3'($urandom_range(0, 5));
        end
        idx = 0;
        base = delivered;
        for (int c = 0; c < 4; c++) begin
            step_a(1'b1, pb_d[idx], pb_o[idx], 1'b0, took);
            if (took) idx++;
        end
        check("bp_accepts", 32'(idx), 32'd2);
        check("bp_in_ready_low", {31'd0, a_in_ready}, 32'd0);
        n = 0;
        while ((idx < 5 || exp_q.size() != 0) && n < 30) begin
            if (idx < 5) step_a(1'b1, pb_d[idx], pb_o[idx], 1'b1, took);
            else step_a(1'b0, 16'd0, 3'd0, 1'b1, took);
            if (took) idx++;
            n++;
        end
        check("bp_delivered", 32'(delivered - base), 32'd5);
        drain_a();

        // full throughput: 16 back-to-back bundles
        base = delivered;
        first_c = -1;
        last_c = -1;
        idx = 0;
        for (int c = 1; c <= 20; c++) begin
            n = delivered;
            step_a(c <= 16, 16'($urandom), 3'($urandom_range(0, 5)), 1'b1, took);
            if (took) idx++;
            if (delivered != n) begin
                if (first_c < 0) first_c = c;
                last_c = c;
            end
        end
        check("tp_accepts", 32'(idx), 32'd16);
        check("tp_first_cycle", 32'(first_c), 32'd3);
        check("tp_last_cycle", 32'(last_c), 32'd18);
        check("tp_delivered", 32'(delivered - base), 32'd16);
        drain_a();

        // reset with an op_err result waiting in S2
        step_a(1'b1, 16'h1234, 3'd6, 1'b0, took);
        step_a(1'b0, 16'd0, 3'd0, 1'b0, took);
        step_a(1'b0, 16'd0, 3'd0, 1'b0, took);
        check("pre_rst_op_err", {31'd0, a_op_err}, 32'd1);
        reset_mid("rstA");

        // reset with both stages full, then only new bundles may appear
        step_a(1'b1, 16'h0C30, 3'd0, 1'b0, took);
        step_a(1'b1, 16'hA55A, 3'd2, 1'b0, took);
        step_a(1'b0, 16'd0, 3'd0, 1'b0, took);
        check("pre_rst_full", {30'd0, a_out_valid, a_in_ready}, 32'd2);
        reset_mid("rstB");
        base = delivered;
        step_a(1'b1, 16'h00FF, 3'd1, 1'b1, took);
        step_a(1'b1, 16'hF00F, 3'd5, 1'b1, took);
        step_a(1'b1, 16'h8001, 3'd3, 1'b1, took);
        drain_a();
        check("post_rst_delivered", 32'(delivered - base), 32'd3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
